// File: rtl/eip_len_adder_if.sv
// Decode-to-agen bundle for the next-EIP generator: decode-side inputs and
// the registered results handed to address generation.
interface eip_len_adder_if;
    logic         en;
    logic [31:0]  de_eip;
    logic [3:0]   de_eip_len;
    logic [2:0]   pfx_sel;
    logic [127:0] de_lower_16bytes;
    logic [31:0]  agen_next_eip;
    logic         agen_next_eip_cout;
    logic [15:0]  agen_ptr_cs;

    modport master (
        output en, de_eip, de_eip_len, pfx_sel, de_lower_16bytes,
        input  agen_next_eip, agen_next_eip_cout, agen_ptr_cs
    );

    modport slave (
        input  en, de_eip, de_eip_len, pfx_sel, de_lower_16bytes,
        output agen_next_eip, agen_next_eip_cout, agen_ptr_cs
    );
endinterface

// File: rtl/eip_len_adder.sv
// Next-EIP generator: sixteen conditional-sum adds of EIP+1..EIP+16 picked by the
// decoded length, plus far-pointer CS extraction by prefix count, registered once.

module cond_sum32 (
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        cin,
    output logic [31:0] s,
    output logic        cout
);
    // Level 0: every 4-bit group precomputes its sum for carry-in 0 and 1.
    logic [31:0] s0_g, s1_g;
    logic [7:0]  c0_g, c1_g;
    // Levels 1..3: blocks of 8, 16 and 32 bits, merged by the lower half's carry.
    logic [31:0] s0_8, s1_8, s0_16, s1_16, s0_32, s1_32;
    logic [3:0]  c0_8, c1_8;
    logic [1:0]  c0_16, c1_16;
    logic        c0_32, c1_32;

    always_comb begin
        s0_g = '0;
        s1_g = '0;
        c0_g = '0;
        c1_g = '0;
        for (int g = 0; g < 8; g++) begin
            {c0_g[g], s0_g[g*4 +: 4]} = {1'b0, a[g*4 +: 4]} + {1'b0, b[g*4 +: 4]};
            {c1_g[g], s1_g[g*4 +: 4]} = {1'b0, a[g*4 +: 4]} + {1'b0, b[g*4 +: 4]} + 5'd1;
        end
    end

    always_comb begin
        s0_8 = '0;
        s1_8 = '0;
        c0_8 = '0;
        c1_8 = '0;
        for (int k = 0; k < 4; k++) begin
            s0_8[k*8 +: 4]     = s0_g[k*8 +: 4];
            s1_8[k*8 +: 4]     = s1_g[k*8 +: 4];
            s0_8[k*8+4 +: 4]   = c0_g[2*k] ? s1_g[k*8+4 +: 4] : s0_g[k*8+4 +: 4];
            s1_8[k*8+4 +: 4]   = c1_g[2*k] ? s1_g[k*8+4 +: 4] : s0_g[k*8+4 +: 4];
            c0_8[k]            = c0_g[2*k] ? c1_g[2*k+1] : c0_g[2*k+1];
            c1_8[k]            = c1_g[2*k] ? c1_g[2*k+1] : c0_g[2*k+1];
        end
    end

    always_comb begin
        s0_16 = '0;
        s1_16 = '0;
        c0_16 = '0;
        c1_16 = '0;
        for (int k = 0; k < 2; k++) begin
            s0_16[k*16 +: 8]   = s0_8[k*16 +: 8];
            s1_16[k*16 +: 8]   = s1_8[k*16 +: 8];
            s0_16[k*16+8 +: 8] = c0_8[2*k] ? s1_8[k*16+8 +: 8] : s0_8[k*16+8 +: 8];
            s1_16[k*16+8 +: 8] = c1_8[2*k] ? s1_8[k*16+8 +: 8] : s0_8[k*16+8 +: 8];
            c0_16[k]           = c0_8[2*k] ? c1_8[2*k+1] : c0_8[2*k+1];
            c1_16[k]           = c1_8[2*k] ? c1_8[2*k+1] : c0_8[2*k+1];
        end
    end

    always_comb begin
        s0_32[15:0]  = s0_16[15:0];
        s1_32[15:0]  = s1_16[15:0];
        s0_32[31:16] = c0_16[0] ? s1_16[31:16] : s0_16[31:16];
        s1_32[31:16] = c1_16[0] ? s1_16[31:16] : s0_16[31:16];
        c0_32        = c0_16[0] ? c1_16[1] : c0_16[1];
        c1_32        = c1_16[0] ? c1_16[1] : c0_16[1];
    end

    assign s    = cin ? s1_32 : s0_32;
    assign cout = cin ? c1_32 : c0_32;
endmodule

module mux32bit_16x1 (
    input  logic [31:0] din [16],
    input  logic [3:0]  sel,
    output logic [31:0] dout
);
    logic [31:0] lvl1 [8];
    logic [31:0] lvl2 [4];
    logic [31:0] lvl3 [2];

    // Binary tree, S0 resolves the first rank.
    always_comb begin
        for (int k = 0; k < 8; k++) lvl1[k] = sel[0] ? din[2*k+1]  : din[2*k];
        for (int k = 0; k < 4; k++) lvl2[k] = sel[1] ? lvl1[2*k+1] : lvl1[2*k];
        for (int k = 0; k < 2; k++) lvl3[k] = sel[2] ? lvl2[2*k+1] : lvl2[2*k];
        dout = sel[3] ? lvl3[1] : lvl3[0];
    end
endmodule

module mux16bit_8x1 (
    input  logic [15:0] din [8],
    input  logic [2:0]  sel,
    output logic [15:0] dout
);
    logic [15:0] lvl1 [4];
    logic [15:0] lvl2 [2];

    always_comb begin
        for (int k = 0; k < 4; k++) lvl1[k] = sel[0] ? din[2*k+1]  : din[2*k];
        for (int k = 0; k < 2; k++) lvl2[k] = sel[1] ? lvl1[2*k+1] : lvl1[2*k];
        dout = sel[2] ? lvl2[1] : lvl2[0];
    end
endmodule

module eip_len_adder (
    input  logic            clk,
    input  logic            rst_n,
    eip_len_adder_if.slave  bus
);
    logic [31:0] nxt_sum [16];
    logic [15:0] nxt_cout;
    logic [31:0] nxt_eip_p0;
    logic        nxt_cout_p0;
    logic [15:0] cs_win [8];
    logic [15:0] ptr_cs_p0;
    logic        win_unused;

    // Every candidate length is summed in parallel so only the select sits
    // behind the length decode on the critical path.
    for (genvar k = 0; k < 16; k++) begin : g_len
        cond_sum32 u_add (
            .a    (bus.de_eip),
            .b    (32'(k + 1)),
            .cin  (1'b0),
            .s    (nxt_sum[k]),
            .cout (nxt_cout[k])
        );
    end

    mux32bit_16x1 u_eip_mux (
        .din  (nxt_sum),
        .sel  (bus.de_eip_len),
        .dout (nxt_eip_p0)
    );

    assign nxt_cout_p0 = nxt_cout[bus.de_eip_len];

    // Selector sits right after the prefixes and the one-byte opcode.
    for (genvar k = 0; k < 8; k++) begin : g_cs
        if (k < 5) begin : g_live
            assign cs_win[k] = bus.de_lower_16bytes[8*k+8 +: 16];
        end else begin : g_tied
            assign cs_win[k] = 16'h0000;
        end
    end

    assign win_unused = ^{bus.de_lower_16bytes[127:56], bus.de_lower_16bytes[7:0]};

    mux16bit_8x1 u_cs_mux (
        .din  (cs_win),
        .sel  (bus.pfx_sel),
        .dout (ptr_cs_p0)
    );

    // Stage boundary: results handed to address generation.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.agen_next_eip      <= 32'h0;
            bus.agen_next_eip_cout <= 1'b0;
            bus.agen_ptr_cs        <= 16'h0;
        end else if (bus.en) begin
            bus.agen_next_eip      <= nxt_eip_p0;
            bus.agen_next_eip_cout <= nxt_cout_p0;
            bus.agen_ptr_cs        <= ptr_cs_p0;
        end
    end
endmodule

// File: tb/tb_eip_len_adder.sv
// Directed bench for eip_len_adder: literal expectations per scenario plus a
// per-cycle comparison against an arithmetic reference model.
module tb_eip_len_adder;
    logic clk;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;

    eip_len_adder_if bus ();

    eip_len_adder dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    logic [31:0] cs_a, cs_b, cs_s;
    logic        cs_cin, cs_cout;

    cond_sum32 u_cs (
        .a    (cs_a),
        .b    (cs_b),
        .cin  (cs_cin),
        .s    (cs_s),
        .cout (cs_cout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Reference: what the registers must hold, from plain arithmetic.
    logic [31:0] m_eip  = 32'h0;
    logic        m_cout = 1'b0;
    logic [15:0] m_cs   = 16'h0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_eip  = 32'h0;
            m_cout = 1'b0;
            m_cs   = 16'h0;
        end else if (bus.en) begin
            {m_cout, m_eip} = {1'b0, bus.de_eip} + 33'(bus.de_eip_len) + 33'd1;
            m_cs = (bus.pfx_sel < 3'd5) ? bus.de_lower_16bytes[8*bus.pfx_sel+8 +: 16] : 16'h0;
        end
    end

    always @(negedge clk) begin
        check("cmp_eip",  {32'h0, bus.agen_next_eip},      {32'h0, m_eip});
        check("cmp_cout", {63'h0, bus.agen_next_eip_cout}, {63'h0, m_cout});
        check("cmp_cs",   {48'h0, bus.agen_ptr_cs},        {48'h0, m_cs});
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_out(input string name, input logic [31:0] eip, input logic cout,
                              input logic [15:0] cs);
        check({name, "_eip"},  {32'h0, bus.agen_next_eip},      {32'h0, eip});
        check({name, "_cout"}, {63'h0, bus.agen_next_eip_cout}, {63'h0, cout});
        check({name, "_cs"},   {48'h0, bus.agen_ptr_cs},        {48'h0, cs});
    endtask

    logic [127:0] idx_win;
    logic [15:0]  ptr_exp [8];
    logic [32:0]  ref_sum;

    initial begin
        for (int k = 0; k < 16; k++) idx_win[8*k +: 8] = 8'(k);
        ptr_exp = '{16'h0201, 16'h0302, 16'h0403, 16'h0504, 16'h0605,
                    16'h0000, 16'h0000, 16'h0000};

        rst_n = 1'b1;
        bus.en = 1'b0;
        bus.de_eip = 32'h0;
        bus.de_eip_len = 4'd0;
        bus.pfx_sel = 3'd0;
        bus.de_lower_16bytes = idx_win;
        #1 rst_n = 1'b0;

        // Adder core against the true 33-bit sum, carry-in exercised.
        for (int i = 0; i < 10000; i++) begin
            cs_a   = $urandom;
            cs_b   = $urandom;
            cs_cin = (i < 4) ? i[0] : 1'($urandom);
            if (i == 0) begin cs_a = 32'hFFFF_FFFF; cs_b = 32'h0; end
            if (i == 1) begin cs_a = 32'hFFFF_FFFF; cs_b = 32'hFFFF_FFFF; end
            #1;
            ref_sum = {1'b0, cs_a} + {1'b0, cs_b} + 33'(cs_cin);
            if ({cs_cout, cs_s} !== ref_sum) begin
                check("cond_sum32", {31'h0, cs_cout, cs_s}, {31'h0, ref_sum});
            end else begin
                checks++;
            end
        end

        step();
        step();
        expect_out("rst_hold", 32'h0, 1'b0, 16'h0);

        rst_n = 1'b1;
        bus.en = 1'b1;
        bus.de_eip = 32'h5555_0000;
        bus.de_eip_len = 4'd0;
        bus.pfx_sel = 3'd0;
        step();
        expect_out("preload", 32'h5555_0001, 1'b0, 16'h0201);

        #2 rst_n = 1'b0;
        #1 expect_out("async_rst", 32'h0, 1'b0, 16'h0);
        bus.de_eip = 32'h0000_1000;
        bus.de_eip_len = 4'd2;
        step();
        expect_out("rst_en_edge", 32'h0, 1'b0, 16'h0);
        rst_n = 1'b1;
        step();
        expect_out("rst_release", 32'h0000_1003, 1'b0, 16'h0201);

        bus.de_eip = 32'h1234_5678;
        for (int i = 0; i < 16; i++) begin
            bus.de_eip_len = 4'(i);
            step();
            check("len_sweep", {32'h0, bus.agen_next_eip}, {32'h0, 32'h1234_5679 + 32'(i)});
        end

        bus.de_eip = 32'hFFFF_FFFF;
        bus.de_eip_len = 4'd0;
        step();
        expect_out("wrap_ff", 32'h0, 1'b1, 16'h0201);
        bus.de_eip = 32'hFFFF_FFF5;
        bus.de_eip_len = 4'd15;
        step();
        expect_out("wrap_f5", 32'h0000_0005, 1'b1, 16'h0201);

        bus.de_eip = 32'h0000_FFFF;
        bus.de_eip_len = 4'd0;
        step();
        expect_out("carry16", 32'h0001_0000, 1'b0, 16'h0201);
        bus.de_eip = 32'h7FFF_FFFF;
        step();
        expect_out("carry31", 32'h8000_0000, 1'b0, 16'h0201);

        for (int p = 0; p < 8; p++) begin
            bus.pfx_sel = 3'(p);
            step();
            check("ptr_sel", {48'h0, bus.agen_ptr_cs}, {48'h0, ptr_exp[p]});
        end

        bus.de_eip = 32'hABCD_0000;
        bus.de_eip_len = 4'd3;
        bus.pfx_sel = 3'd2;
        step();
        expect_out("hold_load", 32'hABCD_0004, 1'b0, 16'h0403);
        bus.en = 1'b0;
        for (int i = 0; i < 5; i++) begin
            bus.de_eip = $urandom;
            bus.de_eip_len = 4'($urandom);
            bus.pfx_sel = 3'($urandom);
            bus.de_lower_16bytes = {$urandom, $urandom, $urandom, $urandom};
            step();
            expect_out("hold", 32'hABCD_0004, 1'b0, 16'h0403);
        end
        bus.en = 1'b1;
        bus.de_eip = 32'h0000_00F0;
        bus.de_eip_len = 4'd15;
        bus.pfx_sel = 3'd4;
        bus.de_lower_16bytes = idx_win;
        step();
        expect_out("hold_release", 32'h0000_0100, 1'b0, 16'h0605);

        step();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
